// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
package sync_fifo_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 9;

  localparam int unsigned MODE_STD  = 0;
  localparam int unsigned MODE_FWFT = 1;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/fifo_dp_ram.sv
// Simple dual-port RAM, one clock, registered read port with async-reset output register.
module fifo_dp_ram
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned DEPTH = 512,
  localparam int unsigned AW = clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  // Storage is deliberately left out of reset so it maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO: pointers, occupancy/flag registers and optional FWFT prefetch
// wrapped around an inferred dual-port RAM.
module param_sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH    = DEFAULT_ADDR_WIDTH,
  parameter int unsigned FWFT          = MODE_STD,
  parameter int unsigned AFULL_THRESH  = 504,
  parameter int unsigned AEMPTY_THRESH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

  if (AFULL_THRESH > DEPTH || AEMPTY_THRESH >= DEPTH || FWFT > MODE_FWFT) begin : g_bad_cfg
    $error("param_sync_fifo: illegal threshold or read-mode configuration");
  end

  logic [CW-1:0]         r_wr_ptr, r_rd_ptr, r_count;
  logic [CW-1:0]         w_wr_ptr_d, w_rd_ptr_d, w_count_d;
  logic                  r_valid, w_valid_d;
  logic                  r_full, r_empty, r_afull, r_aempty, r_overflow, r_underflow;
  logic                  w_full_d, w_empty_d;
  logic                  w_wr_ok, w_pop, w_ram_has, w_ram_rd;
  logic [DATA_WIDTH-1:0] w_ram_q;

  always_comb begin
    w_wr_ok   = wr_en && !r_full;
    w_pop     = rd_en && !r_empty;
    w_ram_has = (r_wr_ptr != r_rd_ptr);
    if (FWFT == MODE_FWFT) begin
      // Refill the output register whenever it is free or being consumed.
      w_ram_rd  = w_ram_has && (!r_valid || w_pop);
      w_valid_d = w_ram_rd || (r_valid && !w_pop);
    end else begin
      w_ram_rd  = w_pop;
      w_valid_d = 1'b0;
    end
    w_wr_ptr_d = r_wr_ptr + CW'(w_wr_ok);
    w_rd_ptr_d = r_rd_ptr + CW'(w_ram_rd);
    w_count_d  = r_count + CW'(w_wr_ok) - CW'(w_pop);
    if (FWFT == MODE_FWFT) begin
      // The RAM pointers exclude the word parked on rd_data, so use the count.
      w_full_d  = (w_count_d == DEPTH_C);
      w_empty_d = !w_valid_d;
    end else begin
      w_full_d  = (w_wr_ptr_d[ADDR_WIDTH-1:0] == w_rd_ptr_d[ADDR_WIDTH-1:0]) &&
                  (w_wr_ptr_d[ADDR_WIDTH] != w_rd_ptr_d[ADDR_WIDTH]);
      w_empty_d = (w_wr_ptr_d == w_rd_ptr_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_valid     <= 1'b0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_afull     <= 1'b0;
      r_aempty    <= 1'b1;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_d;
      r_rd_ptr    <= w_rd_ptr_d;
      r_count     <= w_count_d;
      r_valid     <= w_valid_d;
      r_full      <= w_full_d;
      r_empty     <= w_empty_d;
      r_afull     <= (w_count_d >= AFULL_C);
      r_aempty    <= (w_count_d <= AEMPTY_C);
      r_overflow  <= wr_en && r_full;
      r_underflow <= rd_en && r_empty;
    end
  end

  fifo_dp_ram #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_wr_en   (w_wr_ok),
    .i_wr_addr (r_wr_ptr[ADDR_WIDTH-1:0]),
    .i_wr_data (wr_data),
    .i_rd_en   (w_ram_rd),
    .i_rd_addr (r_rd_ptr[ADDR_WIDTH-1:0]),
    .o_rd_data (w_ram_q)
  );

  assign rd_data      = w_ram_q;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Randomised bench: standard and FWFT instances against queue-based reference models.
module tb_param_sync_fifo;

  localparam int DEPTH = 512;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       wr_en, rd_en, full, empty, afull, aempty, ovf, udf;
  logic [7:0] wr_data, rd_data;
  logic [9:0] count;
  logic       f_wr_en, f_rd_en, f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
  logic [7:0] f_wr_data, f_rd_data;
  logic [9:0] f_count;

  param_sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(9), .FWFT(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .full(full), .empty(empty), .almost_full(afull),
    .almost_empty(aempty), .count(count), .overflow(ovf), .underflow(udf)
  );

  param_sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(9), .FWFT(1)) u_dut_fwft (
    .clk(clk), .rst_n(rst_n), .wr_en(f_wr_en), .wr_data(f_wr_data), .rd_en(f_rd_en),
    .rd_data(f_rd_data), .full(f_full), .empty(f_empty), .almost_full(f_afull),
    .almost_empty(f_aempty), .count(f_count), .overflow(f_ovf), .underflow(f_udf)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference state: held words in order; FWFT words also carry the edge they were written on.
  logic [7:0] sq[$];
  logic [7:0] fq[$];
  int         ft[$];
  int         edge_n = 0;
  logic [7:0] exp_rd;
  logic       exp_ovf, exp_udf, f_exp_ovf, f_exp_udf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit f_visible();
    // A word is on rd_data once it heads the queue and at least one edge followed its write.
    return (fq.size() > 0) && (ft[0] < edge_n);
  endfunction

  task automatic check_all();
    int s;
    int fs;
    bit vis;
    s   = sq.size();
    fs  = fq.size();
    vis = f_visible();
    check_eq("count", 32'(count), 32'(s));
    check_eq("full", 32'(full), 32'(s == DEPTH));
    check_eq("empty", 32'(empty), 32'(s == 0));
    check_eq("almost_full", 32'(afull), 32'(s >= 504));
    check_eq("almost_empty", 32'(aempty), 32'(s <= 8));
    check_eq("overflow", 32'(ovf), 32'(exp_ovf));
    check_eq("underflow", 32'(udf), 32'(exp_udf));
    check_eq("rd_data", 32'(rd_data), 32'(exp_rd));
    check_eq("f_count", 32'(f_count), 32'(fs));
    check_eq("f_full", 32'(f_full), 32'(fs == DEPTH));
    check_eq("f_empty", 32'(f_empty), 32'(!vis));
    check_eq("f_almost_full", 32'(f_afull), 32'(fs >= 504));
    check_eq("f_almost_empty", 32'(f_aempty), 32'(fs <= 8));
    check_eq("f_overflow", 32'(f_ovf), 32'(f_exp_ovf));
    check_eq("f_underflow", 32'(f_udf), 32'(f_exp_udf));
    if (vis) check_eq("f_rd_data", 32'(f_rd_data), 32'(fq[0]));
  endtask

  task automatic tick();
    bit s_wr, s_rd, f_wr, f_rd, vis;
    s_wr    = wr_en && (sq.size() < DEPTH);
    s_rd    = rd_en && (sq.size() > 0);
    exp_ovf = wr_en && (sq.size() == DEPTH);
    exp_udf = rd_en && (sq.size() == 0);
    if (s_rd) exp_rd = sq.pop_front();
    if (s_wr) sq.push_back(wr_data);
    vis       = f_visible();
    f_wr      = f_wr_en && (fq.size() < DEPTH);
    f_rd      = f_rd_en && vis;
    f_exp_ovf = f_wr_en && (fq.size() == DEPTH);
    f_exp_udf = f_rd_en && !vis;
    if (f_rd) begin
      void'(fq.pop_front());
      void'(ft.pop_front());
    end
    if (f_wr) begin
      fq.push_back(f_wr_data);
      ft.push_back(edge_n + 1);
    end
    @(posedge clk);
    edge_n++;
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    f_wr_en = 1'b0; f_rd_en = 1'b0; f_wr_data = '0;
  endtask

  // Asserts reset between edges, checks the flushed state without a clock, then releases.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    sq.delete(); fq.delete(); ft.delete();
    exp_rd = '0; exp_ovf = 1'b0; exp_udf = 1'b0; f_exp_ovf = 1'b0; f_exp_udf = 1'b0;
    check_all();
    idle_inputs();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int guard;
    idle_inputs();
    #1;
    do_reset();

    // Reset in the middle of a burst.
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; wr_data = 8'(i); rd_en = (i > 5);
      f_wr_en = 1'b1; f_wr_data = ~8'(i); f_rd_en = (i > 8);
      tick();
    end
    do_reset();

    // Fill to full, one dropped write, drain, one dropped read.
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      tick();
    end
    wr_data = 8'hEE;
    tick();
    check_eq("t3_count_after_overflow", 32'(count), 32'(DEPTH));
    wr_en = 1'b0; rd_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) tick();
    tick();
    check_eq("t3_rd_data_hold", 32'(rd_data), 32'h0000_00FF);
    rd_en = 1'b0;

    // Wrap-around with random gaps.
    for (int rep = 0; rep < 2; rep++) begin
      n = 0; guard = 0;
      while (n < 300 && guard < 5000) begin
        wr_en = ($urandom_range(0, 3) != 0); wr_data = 8'($urandom);
        if (wr_en) n++;
        tick(); guard++;
      end
      wr_en = 1'b0;
      n = 0; guard = 0;
      while (n < 300 && guard < 5000) begin
        rd_en = ($urandom_range(0, 3) != 0);
        if (rd_en) n++;
        tick(); guard++;
      end
      rd_en = 1'b0;
      check_eq("t4_drained", 32'(count), 32'd0);
    end

    // Simultaneous read/write at count 10, then at count 0.
    wr_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_data = 8'($urandom);
      tick();
    end
    rd_en = 1'b1;
    for (int i = 0; i < 50; i++) begin
      wr_data = 8'($urandom);
      tick();
      check_eq("t5_count_steady", 32'(count), 32'd10);
    end
    wr_en = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    wr_en = 1'b1; wr_data = 8'h3C;
    tick();
    check_eq("t5_write_into_empty", 32'(count), 32'd1);
    wr_en = 1'b0;
    tick();
    rd_en = 1'b0;

    // FWFT: single word latency, then a 16-word back-to-back drain.
    f_wr_en = 1'b1; f_wr_data = 8'hA5;
    tick();
    f_wr_en = 1'b0;
    check_eq("t6_empty_after_1_edge", 32'(f_empty), 32'd1);
    tick();
    check_eq("t6_empty_after_2_edges", 32'(f_empty), 32'd0);
    check_eq("t6_rd_data_a5", 32'(f_rd_data), 32'h0000_00A5);
    f_rd_en = 1'b1;
    tick();
    f_rd_en = 1'b0;
    f_wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      f_wr_data = 8'($urandom);
      tick();
    end
    f_wr_en = 1'b0;
    tick();
    f_rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check_eq("t6_pop_rate", 32'(f_count), 32'(15 - i));
    end
    f_rd_en = 1'b0;
    check_eq("t6_fwft_empty", 32'(f_empty), 32'd1);

    // Random mix on both instances: bias toward filling, then toward draining.
    for (int i = 0; i < 2500; i++) begin
      wr_en = ($urandom_range(0, 3) != 0); wr_data = 8'($urandom);
      rd_en = ($urandom_range(0, 1) != 0);
      f_wr_en = ($urandom_range(0, 3) != 0); f_wr_data = 8'($urandom);
      f_rd_en = ($urandom_range(0, 1) != 0);
      tick();
    end
    for (int i = 0; i < 1500; i++) begin
      wr_en = ($urandom_range(0, 3) == 0); wr_data = 8'($urandom);
      rd_en = ($urandom_range(0, 3) != 0);
      f_wr_en = ($urandom_range(0, 3) == 0); f_wr_data = 8'($urandom);
      f_rd_en = ($urandom_range(0, 3) != 0);
      tick();
    end
    idle_inputs();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
